// File: rtl/lmem_arbiter.sv
// Two-requester layer-memory arbiter: conv engine (0) vs host/debug port (1).
// Round-robin in IDLE, lockable bursts with a bounded hold, registered memory strobes.
module lmem_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [1:0]  lock,
  input  logic [5:0]  sel,
  input  logic [23:0] addr,
  input  logic [39:0] wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [19:0] rdata,
  output logic [1:0]  err,
  output logic        cwr,
  output logic        crd,
  output logic [2:0]  csel,
  output logic [11:0] caddr_wr,
  output logic [11:0] caddr_rd,
  output logic [19:0] cdata_wr,
  input  logic [19:0] cdata_rd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [4:0] HOLD_LIMIT = 5'(MAX_HOLD);

  logic [1:0]  state;
  logic        last_gnt;
  logic [4:0]  cnt;
  logic        rd_owner;

  logic        hold_full;
  logic        accept;
  logic        win;
  logic        owner;
  logic        release_own;
  logic [2:0]  win_sel;
  logic [11:0] win_addr;
  logic [19:0] win_wdata;
  logic        win_we;
  logic        legal;

  assign hold_full = (cnt >= HOLD_LIMIT);
  assign owner     = (state == OWN1);

  always_comb begin
    gnt = '0;
    case (state)
      IDLE:    gnt = (req == 2'b11) ? (last_gnt ? 2'b01 : 2'b10) : req;
      OWN0:    if (req[0] && !(hold_full && req[1])) gnt = 2'b01;
      OWN1:    if (req[1] && !(hold_full && req[0])) gnt = 2'b10;
      default: gnt = '0;
    endcase
  end

  assign accept    = |(req & gnt);
  assign win       = gnt[1];
  assign win_sel   = win ? sel[5:3]     : sel[2:0];
  assign win_addr  = win ? addr[23:12]  : addr[11:0];
  assign win_wdata = win ? wdata[39:20] : wdata[19:0];
  assign win_we    = win ? we[1]        : we[0];
  assign legal     = !((win_sel == 3'b000) || (win_sel == 3'b110) || (win_sel == 3'b111));

  assign release_own = !req[owner] || !lock[owner] || (hold_full && req[!owner]);

  // The transfer that takes the lock counts as the first of the hold window,
  // so a burst yields exactly MAX_HOLD transfers before a forced release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      cnt      <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (accept) begin
        last_gnt <= win;
        if (lock[win]) begin
          state <= win ? OWN1 : OWN0;
          cnt   <= 5'd1;
        end
      end
    end else if (release_own) begin
      state    <= IDLE;
      last_gnt <= owner;
      cnt      <= '0;
    end else if (accept && !hold_full) begin
      cnt <= cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cwr      <= 1'b0;
      crd      <= 1'b0;
      err      <= '0;
      csel     <= '0;
      caddr_wr <= '0;
      caddr_rd <= '0;
      cdata_wr <= '0;
      rd_owner <= 1'b0;
      rvalid   <= '0;
      rdata    <= '0;
    end else begin
      cwr    <= 1'b0;
      crd    <= 1'b0;
      err    <= '0;
      rvalid <= crd ? {rd_owner, !rd_owner} : 2'b00;
      if (crd) rdata <= cdata_rd;
      if (accept) begin
        if (!legal) begin
          err <= gnt;
        end else begin
          csel <= win_sel;
          if (win_we) begin
            cwr      <= 1'b1;
            caddr_wr <= win_addr;
            cdata_wr <= win_wdata;
          end else begin
            crd      <= 1'b1;
            caddr_rd <= win_addr;
            rd_owner <= win;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lmem_arbiter.sv
// Directed bench for lmem_arbiter: reset, reads/writes, round-robin, locked bursts, illegal select, mid-read reset.
module tb_lmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, we, lock;
  logic [5:0]  sel;
  logic [23:0] addr;
  logic [39:0] wdata;
  logic [1:0]  gnt, rvalid, err;
  logic [19:0] rdata, cdata_wr, cdata_rd;
  logic        cwr, crd;
  logic [2:0]  csel;
  logic [11:0] caddr_wr, caddr_rd;

  int errors = 0;
  int checks = 0;

  lmem_arbiter #(.MAX_HOLD(16)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock), .sel(sel),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .err(err), .cwr(cwr), .crd(crd), .csel(csel), .caddr_wr(caddr_wr),
    .caddr_rd(caddr_rd), .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_rr [4];
    logic [1:0] exp_g;
    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};

    reset = 1'b1; req = '0; we = '0; lock = '0; sel = '0;
    addr = '0; wdata = '0; cdata_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_strobes", 32'({cwr, crd}), 32'h0);
    chk("rst_csel", 32'(csel), 32'h0);
    chk("rst_addrs", 32'({caddr_wr, caddr_rd}), 32'h0);
    chk("rst_cdata_wr", 32'(cdata_wr), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_rv_err", 32'({rvalid, err}), 32'h0);
    reset = 1'b0;
    step();

    // Unlocked contention: alternating grants, reads routed back in order
    sel = {3'b010, 3'b001}; we = 2'b00; lock = 2'b00;
    for (int i = 0; i < 6; i++) begin
      req = (i < 4) ? 2'b11 : 2'b00;
      cdata_rd = 20'(32'h01000 + i);
      #1;
      if (i < 4) chk("rr_gnt", 32'(gnt), 32'(exp_rr[i]));
      if (i >= 2) begin
        chk("rr_rvalid", 32'(rvalid), 32'(exp_rr[i-2]));
        chk("rr_rdata", 32'(rdata), 32'h01000 + 32'(i - 1));
      end
      step();
    end

    // Single engine read
    req = 2'b01; we = 2'b00; sel = 6'b000_001; addr = {12'h000, 12'h040}; cdata_rd = 20'h12345;
    #1;
    chk("rd_gnt", 32'(gnt), 32'h1);
    step();
    chk("rd_crd", 32'({cwr, crd}), 32'h1);
    chk("rd_caddr", 32'(caddr_rd), 32'h040);
    chk("rd_csel", 32'(csel), 32'h1);
    req = 2'b00;
    #1;
    chk("rd_idle_gnt", 32'(gnt), 32'h0);
    step();
    chk("rd_rvalid", 32'(rvalid), 32'h1);
    chk("rd_rdata", 32'(rdata), 32'h12345);
    chk("rd_crd_off", 32'(crd), 32'h0);
    step();
    chk("rd_rvalid_off", 32'(rvalid), 32'h0);

    // Host write
    req = 2'b10; we = 2'b10; sel = 6'b101_000; addr = {12'h3FF, 12'h000}; wdata = {20'hABCDE, 20'h00000};
    #1;
    chk("wr_gnt", 32'(gnt), 32'h2);
    step();
    chk("wr_strobes", 32'({cwr, crd}), 32'h2);
    chk("wr_csel", 32'(csel), 32'h5);
    chk("wr_caddr", 32'(caddr_wr), 32'h3FF);
    chk("wr_cdata", 32'(cdata_wr), 32'hABCDE);
    req = 2'b00;
    step();
    chk("wr_cwr_off", 32'(cwr), 32'h0);
    chk("wr_csel_hold", 32'(csel), 32'h5);

    // Illegal select on engine read
    req = 2'b01; we = 2'b00; sel = 6'b000_111;
    #1;
    chk("ill_gnt", 32'(gnt), 32'h1);
    step();
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_crd", 32'(crd), 32'h0);
    chk("ill_csel_hold", 32'(csel), 32'h5);
    req = 2'b00;
    step();
    chk("ill_err_off", 32'(err), 32'h0);
    chk("ill_rvalid", 32'(rvalid), 32'h0);

    // Locked engine burst, host requesting from the second transfer on
    we = 2'b11; sel = {3'b010, 3'b001}; lock = 2'b01;
    for (int i = 0; i < 18; i++) begin
      req = (i == 0) ? 2'b01 : 2'b11;
      exp_g = (i < 16) ? 2'b01 : ((i == 16) ? 2'b00 : 2'b10);
      #1;
      chk("burst_gnt", 32'(gnt), 32'(exp_g));
      step();
    end
    req = 2'b00; lock = 2'b00;
    step();

    // Saturated hold: host idle for 20 transfers, then forced release on first host request
    lock = 2'b01;
    for (int i = 0; i < 22; i++) begin
      req = (i < 20) ? 2'b01 : 2'b11;
      exp_g = (i < 20) ? 2'b01 : ((i == 20) ? 2'b00 : 2'b10);
      #1;
      chk("sat_gnt", 32'(gnt), 32'(exp_g));
      step();
    end
    req = 2'b00; lock = 2'b00;
    step();

    // Reset the cycle after an engine read is accepted
    req = 2'b01; we = 2'b00; sel = 6'b000_001; addr = {12'h000, 12'h055};
    #1;
    chk("rr_pre_gnt", 32'(gnt), 32'h1);
    step();
    chk("rr_pre_crd", 32'(crd), 32'h1);
    req = 2'b00; reset = 1'b1;
    #1;
    chk("rst_crd_drop", 32'(crd), 32'h0);
    step();
    chk("rst_no_rvalid0", 32'(rvalid), 32'h0);
    reset = 1'b0;
    step();
    chk("rst_no_rvalid1", 32'(rvalid), 32'h0);
    step();
    chk("rst_no_rvalid2", 32'(rvalid), 32'h0);
    req = 2'b11; we = 2'b11;
    #1;
    chk("rst_first_gnt", 32'(gnt), 32'h1);
    step();
    req = 2'b00;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lmem_arbiter.md
LMEM_ARBITER -- requirements
Module: lmem_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum consecutive accepted transfers for one locked requester while the other requests.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  2  per-requester access request; bit0 = conv engine, bit1 = host/debug port.
REQ-005 we  input  2  per-requester op: 1 = write, 0 = read.
REQ-006 lock  input  2  per-requester burst hold: keep grant while asserted.
REQ-007 sel  input  6  {sel1,sel0}, 3-bit layer-memory select per requester.
REQ-008 addr  input  24  {addr1,addr0}, 12-bit word address per requester.
REQ-009 wdata  input  40  {wdata1,wdata0}, 20-bit write data per requester.
REQ-010 gnt  output  2  combinational one-hot grant; transfer accepted on an edge where req[i]&gnt[i].
REQ-011 rvalid  output  2  registered one-cycle pulse, read data for requester i on rdata.
REQ-012 rdata  output  20  registered read data, shared by both requesters.
REQ-013 err  output  2  registered one-cycle pulse, illegal select on an accepted transfer.
REQ-014 cwr, crd  output  1 each  registered memory write/read strobes.
REQ-015 csel  output  3  registered memory select.
REQ-016 caddr_wr, caddr_rd  output  12 each  registered memory addresses.
REQ-017 cdata_wr  output  20  registered write data.
REQ-018 cdata_rd  input  20  memory read data, valid in the cycle crd is high.

Function
REQ-019 FSM states IDLE, OWN0, OWN1; OWNi means requester i holds the grant.
REQ-020 IDLE: gnt=0 when req=0; single request wins; both requesting, winner = requester not granted last (last_gnt resets to 1, so engine wins first).
REQ-021 IDLE -> OWNi on the edge accepting a transfer from i with lock[i]=1; otherwise stay IDLE with last_gnt=i.
REQ-022 OWNi: gnt=one-hot(i) whenever req[i]=1; other requester blocked.
REQ-023 OWNi -> IDLE when req[i]=0 or lock[i]=0 (no gnt that cycle if req[i]=0).
REQ-024 Hold counter (5-bit) increments per accepted transfer in OWNi; cleared on entering IDLE/OWNx.
REQ-025 Counter reaching MAX_HOLD with req[other]=1: gnt deasserted, force OWNi -> IDLE, last_gnt=i; other wins next cycle.
REQ-026 Counter saturates at MAX_HOLD when other not requesting; forced release occurs once other requests.
REQ-027 Accepted write: next cycle cwr=1, crd=0, csel, caddr_wr, cdata_wr from winner; one cycle only.
REQ-028 Accepted read: next cycle crd=1, cwr=0, csel, caddr_rd from winner; following cycle rvalid[i]=1, rdata=cdata_rd.
REQ-029 Read latency 2 cycles from accepting edge to rvalid; one transfer per cycle, back-to-back allowed, in order.
REQ-030 Owner tag of in-flight read pipelined with the read; grant switches never misroute rvalid.
REQ-031 sel in {000,110,111} is illegal: transfer accepted, no strobe issued, err[i] pulsed next cycle, no rvalid.
REQ-032 Idle cycles: cwr=crd=0; csel/addresses/cdata_wr retain last values.
REQ-033 gnt never asserted for a requester with req=0; gnt never has two bits set.

Reset
REQ-034 reset high: state IDLE, last_gnt=1, counter 0, cwr=crd=0, csel=0, caddr_wr=caddr_rd=0, cdata_wr=0, rdata=0, rvalid=0, err=0.
REQ-035 Reset mid-transfer discards in-flight reads; no rvalid after release; first post-reset grant goes to engine.

Verification
REQ-036 Single read: req=01, we=0, sel0=001, addr0=0x040, cdata_rd=0x12345 -> crd=1, caddr_rd=0x040 at cycle+1; rvalid=01, rdata=0x12345 at cycle+2.
REQ-037 Simultaneous unlocked req=11 for 4 cycles -> gnt sequence 01,10,01,10.
REQ-038 Engine locked burst, host requesting, MAX_HOLD=16 -> 16 engine transfers, one gap cycle with gnt=00, then gnt=10.
REQ-039 Write sel1=101, addr1=0x3FF, wdata1=0xABCDE -> next cycle cwr=1, csel=101, caddr_wr=0x3FF, cdata_wr=0xABCDE.
REQ-040 Read with sel0=111 -> err=01 next cycle, crd stays 0, no rvalid.
REQ-041 reset asserted cycle after read accept -> crd drops immediately, rvalid never pulses, req=11 after release gives gnt=01.
